// File: rtl/muldiv_unit_if.sv
// Operation/result handshake bundle between the execute stage and the iterative mul/div unit.
// The master issues operations and takes results; the slave is the unit itself.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             word;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op, word, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, word, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2^MUL_BITS shift-add multiplier and restoring
// divider sharing one 2*WIDTH accumulator, with a hold-until-taken result handshake.
module muldiv_unit #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned MUL_BITS = 2
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam int unsigned PW    = WIDTH + MUL_BITS;
  localparam int unsigned NFull = WIDTH / MUL_BITS;
  localparam int unsigned NWord = 32 / MUL_BITS;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [2:0]           op_q, op_d;
  logic                 word_q, word_d;
  logic                 neg_q, neg_d;
  logic                 sa_q, sa_d;

  logic                 accept, is_div, sgn_a, sgn_b, neg_a, neg_b, b_zero, ovf, special;
  logic [WIDTH-1:0]     a_ext, b_ext, mag_a, mag_b, min_val, spec_res, fix_res;
  logic [WIDTH-1:0]     q_fix, r_fix;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [PW-1:0]        partial, sum;
  logic [WIDTH:0]       r_sh, diff;

  function automatic logic [WIDTH-1:0] sext32(input logic [31:0] x);
    logic signed [WIDTH-1:0] t;
    t = $signed(x);
    return t;
  endfunction

  // Operand decode for the operation currently offered.
  always_comb begin
    is_div = bus.op[2];
    sgn_a  = is_div ? ~bus.op[0] : (bus.op == 3'd1 || bus.op == 3'd2);
    sgn_b  = is_div ? ~bus.op[0] : (bus.op == 3'd1);
    if (bus.word) begin
      a_ext   = (is_div && sgn_a) ? sext32(bus.a[31:0]) : WIDTH'(bus.a[31:0]);
      b_ext   = (is_div && sgn_b) ? sext32(bus.b[31:0]) : WIDTH'(bus.b[31:0]);
      min_val = sext32(32'h8000_0000);
    end else begin
      a_ext   = bus.a;
      b_ext   = bus.b;
      min_val = {1'b1, {(WIDTH-1){1'b0}}};
    end
    neg_a   = sgn_a & a_ext[WIDTH-1];
    neg_b   = sgn_b & b_ext[WIDTH-1];
    mag_a   = neg_a ? -a_ext : a_ext;
    mag_b   = neg_b ? -b_ext : b_ext;
    b_zero  = (b_ext == '0);
    ovf     = sgn_a && (a_ext == min_val) && (b_ext == '1);
    special = is_div && (b_zero || ovf);
    if (b_zero) begin
      spec_res = bus.op[1] ? (bus.word ? sext32(bus.a[31:0]) : bus.a) : '1;
    end else begin
      spec_res = bus.op[1] ? '0 : min_val;
    end
  end

  // One iteration of each datapath; the multiplier keeps its product in the upper half and
  // shifts the consumed multiplier bits out of the lower half.
  always_comb begin
    partial  = PW'(mcand_q) * PW'(acc_q[MUL_BITS-1:0]);
    sum      = PW'(acc_q[2*WIDTH-1:WIDTH]) + partial;
    mul_next = {sum, acc_q[WIDTH-1:MUL_BITS]};
    r_sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff     = r_sh - {1'b0, mcand_q};
    div_next = diff[WIDTH] ? {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Word multiplies run only 32 bits deep, so their product sits at acc_q[WIDTH-1 -: 32].
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    q_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_fix   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_res = '0;
    case (op_q)
      3'd0:             fix_res = word_q ? sext32(acc_q[WIDTH-1:WIDTH-32]) : prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       fix_res = word_q ? sext32(q_fix[31:0]) : q_fix;
      default:          fix_res = word_q ? sext32(r_fix[31:0]) : r_fix;
    endcase
  end

  assign accept = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    if (bus.flush && state_q != StIdle) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_d   = bus.op;
            word_d = bus.word;
            neg_d  = neg_a ^ neg_b;
            sa_d   = neg_a;
            if (special) begin
              result_d = spec_res;
              state_d  = StDone;
            end else if (is_div) begin
              mcand_d = mag_b;
              acc_d   = {{WIDTH{1'b0}}, bus.word ? (mag_a << (WIDTH - 32)) : mag_a};
              cnt_d   = bus.word ? CntW'(31) : CntW'(WIDTH - 1);
              state_d = StDiv;
            end else begin
              mcand_d = mag_a;
              acc_d   = {{WIDTH{1'b0}}, mag_b};
              cnt_d   = bus.word ? CntW'(NWord - 1) : CntW'(NFull - 1);
              state_d = StMul;
            end
          end
        end
        StMul: begin
          acc_d = mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = StFix;
        end
        StDiv: begin
          acc_d = div_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = StFix;
        end
        StFix: begin
          result_d = fix_res;
          state_d  = StDone;
        end
        StDone: begin
          if (bus.out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && reset;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative RV64M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Accepts one operation at a time over a valid/ready handshake and iterates over several cycles.
- Presents the result with a hold-until-taken output handshake, so the execute stage can raise its stall while busy and the memory stage can back-pressure it.
- Supports full-width and word (W) modes, signed/unsigned variants, and RISC-V corner-case results.

Parameters:
- WIDTH, 64, operand/result width in bits (32 or 64).
- MUL_BITS, 2, multiplier bits retired per cycle (1, 2 or 4); must divide 32.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept an operation.
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- word  in  1  W-variant: use a[31:0]/b[31:0], sign-extend the 32-bit result.
- a  in  WIDTH  rs1 operand.
- b  in  WIDTH  rs2 operand.
- flush  in  1  abort the current operation (branch redirect).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result (driven by !stopm).
- result  out  WIDTH  operation result.
- busy  out  1  operation in flight or result not yet taken; feeds the stage stall.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, out_valid=0, result=0, busy=0, in_ready=1 after reset.
  - Takes effect even mid-operation; the partial result is discarded.
- in_ready = (state==IDLE) && reset. Acceptance is in_valid && in_ready && !flush. There is no overlap; a new operation is accepted only in IDLE.
- busy = (state!=IDLE).
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE -> MUL on accept when op<4. Operands are latched:
  - word: a, b zero-extended from bit 31 (MUL only).
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
  - Magnitudes and result sign are recorded.
- MUL:
  - Shift-add on magnitudes, 2*WIDTH-bit accumulator, MUL_BITS per cycle.
  - Runs N = L/MUL_BITS cycles, where L=32 if word, else WIDTH. Counter counts N-1 down to 0.
  - Moves to FIX when the counter reaches 0.
- IDLE -> DIV on accept when op>=4, unless a special case applies (below).
  - Restoring division, 1 quotient bit per cycle, L cycles, on magnitudes.
  - DIV/REM are signed; DIVU/REMU are unsigned. Word operands are sign-extended (signed ops) or zero-extended (unsigned ops) from bit 31.
- FIX (1 cycle):
  - Negates per recorded sign. Quotient sign = sa^sb; remainder sign = sa.
  - Selects low half (MUL), high half (MULH*), quotient or remainder.
  - In word mode, sign-extends bit 31 of the result to WIDTH.
  - Registers result and goes to DONE.
- Special cases go IDLE -> DONE directly, with the result registered at accept:
  - Divide by zero (b==0 in effective width): quotient = all ones; remainder = a (effective width, sign-extended if word).
  - Signed overflow (a==MIN, b==-1, effective width): quotient = MIN; remainder = 0.
- DONE:
  - out_valid=1 and result is held stable while out_ready==0.
  - On out_ready==1 -> IDLE; out_valid drops the next cycle.
- Latency from the accept edge to the first out_valid cycle:
  - MUL class: N+1 edges (MUL N, FIX 1).
  - DIV class: L+1 edges.
  - Special case: 1 edge.
  - Example: WIDTH=64, MUL_BITS=2 gives MUL 33, MULW 17, DIV 65, DIVW 33.
- flush:
  - In MUL/DIV/FIX/DONE: state -> IDLE at the next edge, out_valid=0; the result is never presented.
  - In IDLE: blocks acceptance that cycle.
- Priority: reset > flush > handshake.
- Arithmetic is modulo 2^WIDTH. MULHU of two all-ones operands returns all-ones minus 1 in the high half (0xFFFF_FFFF_FFFF_FFFE).

Test Plan:
- MUL a=7, b=-3 (WIDTH=64, MUL_BITS=2): in_ready drops the cycle after accept; out_valid appears 33 edges later; result=0xFFFF_FFFF_FFFF_FFEB; busy drops the cycle after the out_ready handshake.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. MULHSU a=-1, b=2 -> result=0xFFFF_FFFF_FFFF_FFFF. MULW a=0x8000_0000, b=2 -> result=0.
- DIV a=-7, b=2 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD) after 65 edges. REM same operands -> 0xFFFF_FFFF_FFFF_FFFF. DIVUW a=0xFFFF_FFFF, b=1 -> 0xFFFF_FFFF_FFFF_FFFF after 33 edges.
- Corner cases, each with out_valid 1 edge after accept:
  - DIV a=5, b=0 -> all ones.
  - REMU a=5, b=0 -> 5.
  - DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; REM same operands -> 0.
  - DIVW a=0x8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> result stable, out_valid=1, in_ready=0. Then out_ready=1 -> IDLE, and a new op is accepted the following cycle.
- Flush/reset mid-operation:
  - flush at iteration 20 of a DIV -> IDLE next edge; out_valid never rises; the next op result is correct.
  - reset=0 during MUL -> all outputs at reset values next edge.
  - flush with in_valid in IDLE -> not accepted.
